// File: rtl/spi_frame_pkg.sv
// Shared types and command-field constants for the SPI frame decoder.
package spi_frame_pkg;

  typedef enum logic [2:0] {
    StCmd,
    StAddr,
    StWdata,
    StRreq,
    StRwait,
    StRsend
  } state_e;

  localparam int unsigned CMD_WRITE_BIT = 7;
  localparam int unsigned CMD_INC_BIT   = 6;
  localparam int unsigned CMD_LEN_MSB   = 5;

endpackage

// File: rtl/spi_frame_decoder.sv
// Decodes SPI command frames (cmd, addr, data...) into register-bus writes/reads and
// returns read data on an AXI-Stream master.
module spi_frame_decoder
  import spi_frame_pkg::*;
#(
  parameter int unsigned DEST_WIDTH = 8,
  parameter int unsigned ID_WIDTH = 8,
  parameter logic [DEST_WIDTH-1:0] AXIS_DEST = '0,
  parameter logic [ID_WIDTH-1:0] AXIS_SOURCE = '0
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  frame_start,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [7:0]            rf_addr,
  output logic [7:0]            rf_wdata,
  output logic                  rf_write,
  output logic                  rf_read,
  input  logic [7:0]            rf_rdata,
  input  logic                  rf_rvalid,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  input  logic                  m_axis_tready,
  output logic                  err_abort
);

  state_e     r_state, w_state_d;
  logic       r_wr, w_wr_d;
  logic       r_inc, w_inc_d;
  logic [6:0] r_rem, w_rem_d;
  logic [7:0] w_addr_d, w_wdata_d, w_tdata_d;
  logic       w_write_d, w_read_d, w_tvalid_d, w_tlast_d, w_abort_d;
  logic       w_accept;
  logic       w_last;

  assign s_axis_tready = !res && !frame_start &&
                         (r_state == StCmd || r_state == StAddr || r_state == StWdata);
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_last        = (r_rem == 7'd1);
  assign m_axis_tdest  = AXIS_DEST;
  assign m_axis_tid    = AXIS_SOURCE;

  always_comb begin
    w_state_d  = r_state;
    w_wr_d     = r_wr;
    w_inc_d    = r_inc;
    w_rem_d    = r_rem;
    w_addr_d   = rf_addr;
    w_wdata_d  = rf_wdata;
    w_tdata_d  = m_axis_tdata;
    w_write_d  = 1'b0;
    w_read_d   = 1'b0;
    w_tvalid_d = m_axis_tvalid;
    w_tlast_d  = m_axis_tlast;
    w_abort_d  = 1'b0;

    // Address advances in the cycle the access is presented on the bus.
    if (r_inc && (rf_write || rf_read)) begin
      w_addr_d = rf_addr + 8'd1;
    end

    if (frame_start) begin
      w_state_d  = StCmd;
      w_tvalid_d = 1'b0;
      w_tlast_d  = 1'b0;
      w_abort_d  = (r_state != StCmd);
    end else begin
      unique case (r_state)
        StCmd: begin
          if (w_accept) begin
            w_wr_d    = s_axis_tdata[CMD_WRITE_BIT];
            w_inc_d   = s_axis_tdata[CMD_INC_BIT];
            w_rem_d   = {1'b0, s_axis_tdata[CMD_LEN_MSB:0]} + 7'd1;
            w_state_d = StAddr;
          end
        end
        StAddr: begin
          if (w_accept) begin
            w_addr_d  = s_axis_tdata;
            w_state_d = r_wr ? StWdata : StRreq;
          end
        end
        StWdata: begin
          if (w_accept) begin
            w_write_d = 1'b1;
            w_wdata_d = s_axis_tdata;
            w_rem_d   = r_rem - 7'd1;
            if (w_last) w_state_d = StCmd;
          end
        end
        StRreq: begin
          w_read_d  = 1'b1;
          w_state_d = StRwait;
        end
        StRwait: begin
          if (rf_rvalid) begin
            w_tdata_d  = rf_rdata;
            w_tvalid_d = 1'b1;
            w_tlast_d  = w_last;
            w_state_d  = StRsend;
          end
        end
        StRsend: begin
          if (m_axis_tready) begin
            w_tvalid_d = 1'b0;
            w_tlast_d  = 1'b0;
            w_rem_d    = r_rem - 7'd1;
            w_state_d  = w_last ? StCmd : StRreq;
          end
        end
        default: w_state_d = StCmd;
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state       <= StCmd;
      r_wr          <= 1'b0;
      r_inc         <= 1'b0;
      r_rem         <= 7'd0;
      rf_addr       <= 8'h00;
      rf_wdata      <= 8'h00;
      rf_write      <= 1'b0;
      rf_read       <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      err_abort     <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_wr          <= w_wr_d;
      r_inc         <= w_inc_d;
      r_rem         <= w_rem_d;
      rf_addr       <= w_addr_d;
      rf_wdata      <= w_wdata_d;
      rf_write      <= w_write_d;
      rf_read       <= w_read_d;
      m_axis_tdata  <= w_tdata_d;
      m_axis_tvalid <= w_tvalid_d;
      m_axis_tlast  <= w_tlast_d;
      err_abort     <= w_abort_d;
    end
  end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed bench for spi_frame_decoder: write, read, wrap, backpressure, abort and reset.
module tb_spi_frame_decoder;
  import spi_frame_pkg::*;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       frame_start = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] rf_addr, rf_wdata;
  logic       rf_write, rf_read;
  logic [7:0] rf_rdata = 8'h00;
  logic       rf_rvalid = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast;
  logic [7:0] m_axis_tdest, m_axis_tid;
  logic       m_tready = 1'b1;
  logic       err_abort;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] wr_log[$];
  logic [7:0]  rd_log[$];
  logic [8:0]  ax_log[$];
  logic [7:0]  rd_q[$];
  int          overlap = 0;
  int          unstable = 0;
  int          pend = 0;
  logic        hold_v = 1'b0;
  logic [8:0]  hold_prev = '0;

  spi_frame_decoder #(
    .DEST_WIDTH (8),
    .ID_WIDTH   (8),
    .AXIS_DEST  (8'h3C),
    .AXIS_SOURCE(8'hA5)
  ) dut (
    .clk          (clk),
    .res          (res),
    .frame_start  (frame_start),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_axis_tready),
    .rf_addr      (rf_addr),
    .rf_wdata     (rf_wdata),
    .rf_write     (rf_write),
    .rf_read      (rf_read),
    .rf_rdata     (rf_rdata),
    .rf_rvalid    (rf_rvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tdest (m_axis_tdest),
    .m_axis_tid   (m_axis_tid),
    .m_axis_tready(m_tready),
    .err_abort    (err_abort)
  );

  always #5 clk = ~clk;

  // Register-file model: answers each rf_read with the next queued byte, 2 cycles later.
  always @(posedge clk) begin
    #1;
    rf_rvalid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0 && rd_q.size() > 0) begin
        rf_rvalid = 1'b1;
        rf_rdata  = rd_q.pop_front();
      end
    end
    if (rf_read) pend = 2;
  end

  always @(negedge clk) begin
    if (!res) begin
      if (rf_write) wr_log.push_back({rf_addr, rf_wdata});
      if (rf_read) begin
        rd_log.push_back(rf_addr);
        if (m_axis_tvalid) overlap++;
      end
      if (hold_v && m_axis_tvalid && ({m_axis_tlast, m_axis_tdata} !== hold_prev)) unstable++;
      if (m_axis_tvalid && m_tready) begin
        ax_log.push_back({m_axis_tlast, m_axis_tdata});
        hold_v = 1'b0;
      end else begin
        hold_v    = m_axis_tvalid;
        hold_prev = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  // All stimulus tasks start and end at posedge + 1.
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_tvalid = 1'b0;
    n_cmp++;
    if (!acc) begin
      n_err++;
      $display("FAIL send_byte_%h: accepted=%b required=1", b, acc);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    ax_log.delete();
    overlap = 0;
    unstable = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({s_axis_tready, rf_write, rf_read, m_axis_tvalid, m_axis_tlast, err_abort} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b required 000000",
               {s_axis_tready, rf_write, rf_read, m_axis_tvalid, m_axis_tlast, err_abort});
    end
    n_cmp++;
    if ({rf_addr, rf_wdata, m_axis_tdata} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h required 000000", {rf_addr, rf_wdata, m_axis_tdata});
    end
    n_cmp++;
    if ({m_axis_tdest, m_axis_tid} !== 16'h3CA5) begin
      n_err++;
      $display("FAIL dest_id: got %h required 3ca5", {m_axis_tdest, m_axis_tid});
    end
    res = 1'b0;
    #1;
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: got %b required 1", s_axis_tready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    logic [7:0] dat[3];
    dat[0] = 8'hAA;
    dat[1] = 8'hBB;
    dat[2] = 8'hCC;
    clear_logs();
    pulse_frame();
    send_byte(8'hC2);
    send_byte(8'h10);
    for (int i = 0; i < 3; i++) begin
      send_byte(dat[i]);
      n_cmp++;
      if ({rf_write, rf_addr, rf_wdata} !== {1'b1, 8'h10 + 8'(i), dat[i]}) begin
        n_err++;
        $display("FAIL write_%0d: got %b/%h/%h required 1/%h/%h", i, rf_write, rf_addr,
                 rf_wdata, 8'h10 + 8'(i), dat[i]);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (wr_log.size() != 3 || rf_write !== 1'b0 || dut.r_state !== StCmd) begin
      n_err++;
      $display("FAIL write_end: got n=%0d wr=%b st=%0d required n=3 wr=0 st=%0d",
               wr_log.size(), rf_write, dut.r_state, StCmd);
    end
  endtask

  task automatic test_read_wrap();
    int i;
    clear_logs();
    rd_q.push_back(8'h5A);
    rd_q.push_back(8'h5B);
    m_tready = 1'b1;
    pulse_frame();
    send_byte(8'h01);
    send_byte(8'hFF);
    i = 0;
    while (ax_log.size() < 2 && i < 200) begin
      @(posedge clk);
      i++;
    end
    #1;
    n_cmp++;
    if (rd_log.size() != 2 || rd_log[0] !== 8'hFF || rd_log[1] !== 8'hFF) begin
      n_err++;
      $display("FAIL read_addr: got n=%0d required 2 reads at ff", rd_log.size());
    end
    n_cmp++;
    if (ax_log.size() != 2 || ax_log[0] !== 9'h05A || ax_log[1] !== 9'h15B) begin
      n_err++;
      $display("FAIL read_stream: got n=%0d required 05a,15b", ax_log.size());
    end
    n_cmp++;
    if (dut.r_state !== StCmd || m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL read_end: got st=%0d v=%b required st=%0d v=0",
               dut.r_state, m_axis_tvalid, StCmd);
    end
  endtask

  task automatic test_inc_wrap();
    clear_logs();
    pulse_frame();
    send_byte(8'hC1);
    send_byte(8'hFF);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_log.size() != 2 || wr_log[0] !== 16'hFF11 || wr_log[1] !== 16'h0022) begin
      n_err++;
      $display("FAIL inc_wrap: got n=%0d required ff11,0022", wr_log.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d[3];
    int         i;
    exp_d[0] = 8'h01;
    exp_d[1] = 8'h02;
    exp_d[2] = 8'h03;
    clear_logs();
    for (int k = 0; k < 3; k++) rd_q.push_back(exp_d[k]);
    m_tready = 1'b0;
    pulse_frame();
    send_byte(8'h42);
    send_byte(8'h20);
    for (int k = 0; k < 3; k++) begin
      i = 0;
      while (!m_axis_tvalid && i < 50) begin
        @(posedge clk);
        #1;
        i++;
      end
      repeat (5) @(posedge clk);
      #1;
      n_cmp++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, k == 2, exp_d[k]}) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got %b/%b/%h required 1/%b/%h", k, m_axis_tvalid,
                 m_axis_tlast, m_axis_tdata, k == 2, exp_d[k]);
      end
      m_tready = 1'b1;
      @(posedge clk);
      #1;
      m_tready = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    m_tready = 1'b1;
    n_cmp++;
    if (rd_log.size() != 3 || rd_log[0] !== 8'h20 || rd_log[1] !== 8'h21 ||
        rd_log[2] !== 8'h22 || overlap != 0) begin
      n_err++;
      $display("FAIL bp_reads: got n=%0d overlap=%0d required 3 reads 20..22 overlap=0",
               rd_log.size(), overlap);
    end
    n_cmp++;
    if (ax_log.size() != 3 || ax_log[0] !== 9'h001 || ax_log[1] !== 9'h002 ||
        ax_log[2] !== 9'h103 || unstable != 0) begin
      n_err++;
      $display("FAIL bp_stream: got n=%0d unstable=%0d required 001,002,103 unstable=0",
               ax_log.size(), unstable);
    end
  endtask

  task automatic test_abort();
    clear_logs();
    pulse_frame();
    send_byte(8'h03);
    send_byte(8'h30);
    @(posedge clk);
    #1;
    n_cmp++;
    if (dut.r_state !== StRwait) begin
      n_err++;
      $display("FAIL abort_setup: got st=%0d required %0d", dut.r_state, StRwait);
    end
    pulse_frame();
    n_cmp++;
    if ({err_abort, m_axis_tvalid} !== 2'b10 || dut.r_state !== StCmd) begin
      n_err++;
      $display("FAIL abort_pulse: got ab=%b v=%b st=%0d required 1/0/%0d", err_abort,
               m_axis_tvalid, dut.r_state, StCmd);
    end
    pulse_frame();
    n_cmp++;
    if (err_abort !== 1'b0) begin
      n_err++;
      $display("FAIL abort_once: got %b required 0", err_abort);
    end
    send_byte(8'hC0);
    send_byte(8'h05);
    send_byte(8'h77);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_log.size() != 1 || wr_log[0] !== 16'h0577) begin
      n_err++;
      $display("FAIL abort_next: got n=%0d required 0577", wr_log.size());
    end
  endtask

  task automatic test_reset_mid();
    logic seen_abort;
    clear_logs();
    pulse_frame();
    send_byte(8'hC3);
    send_byte(8'h40);
    send_byte(8'h11);
    #1;
    res = 1'b1;
    #1;
    n_cmp++;
    if ({s_axis_tready, rf_write, rf_read, m_axis_tvalid, m_axis_tlast, err_abort} !== 6'b0 ||
        {rf_addr, rf_wdata, m_axis_tdata} !== 24'h0 || dut.r_state !== StCmd) begin
      n_err++;
      $display("FAIL async_reset: got ctl=%b data=%h st=%0d required 0/000000/%0d",
               {s_axis_tready, rf_write, rf_read, m_axis_tvalid, m_axis_tlast, err_abort},
               {rf_addr, rf_wdata, m_axis_tdata}, dut.r_state, StCmd);
    end
    @(posedge clk);
    #1;
    res = 1'b0;
    wr_log.delete();
    seen_abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      seen_abort |= err_abort;
    end
    send_byte(8'hC0);
    send_byte(8'h07);
    send_byte(8'h99);
    seen_abort |= err_abort;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (seen_abort !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_abort: got %b required 0", seen_abort);
    end
    n_cmp++;
    if (wr_log.size() != 1 || wr_log[0] !== 16'h0799) begin
      n_err++;
      $display("FAIL reset_recover: got n=%0d required 0799", wr_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wrap();
    test_inc_wrap();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
